// File: rtl/pcm_sample_scheduler_pkg.sv
// Shared codes for the PCM sample scheduler: source-select values, FSM state
// encodings and the saturating underrun counter step.
package pcm_sample_scheduler_pkg;

   typedef logic [1:0] sel_t;
   typedef logic [1:0] state_t;

   localparam sel_t SEL_SRC0 = 2'd0;
   localparam sel_t SEL_SRC1 = 2'd1;
   localparam sel_t SEL_PRIO = 2'd2;
   localparam sel_t SEL_MUTE = 2'd3;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_FETCH = 2'd1;
   localparam state_t ST_UNDER = 2'd2;
   localparam state_t ST_MUTE  = 2'd3;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/pcm_sample_scheduler_if.sv
// Bus between the sound sources / hdmi_tx side and the PCM sample scheduler.
interface pcm_sample_scheduler_if #(
   parameter int PCM_WIDTH = 24
);
   // Handshake: a sample transfers on every cycle where srcN_valid and srcN_ready
   // are both high. ready is only raised while a fetch is pending; in priority
   // mode it may depend on valid, so sources must not wait for ready before valid.
   logic [1:0]           sel;
   logic                 src0_valid;
   logic                 src0_ready;
   logic [PCM_WIDTH-1:0] src0_l;
   logic [PCM_WIDTH-1:0] src0_r;
   logic                 src1_valid;
   logic                 src1_ready;
   logic [PCM_WIDTH-1:0] src1_l;
   logic [PCM_WIDTH-1:0] src1_r;
   logic                 pcm_fs;
   logic [PCM_WIDTH-1:0] pcm_l;
   logic [PCM_WIDTH-1:0] pcm_r;
   logic [7:0]           underrun_count;
   logic [1:0]           dbg_state;

   modport slave (
      input  sel, src0_valid, src0_l, src0_r, src1_valid, src1_l, src1_r,
      output src0_ready, src1_ready, pcm_fs, pcm_l, pcm_r, underrun_count, dbg_state
   );

   modport master (
      output sel, src0_valid, src0_l, src0_r, src1_valid, src1_l, src1_r,
      input  src0_ready, src1_ready, pcm_fs, pcm_l, pcm_r, underrun_count, dbg_state
   );
endinterface

// File: rtl/pcm_sample_scheduler_fs_phase_accum.sv
// Fractional phase accumulator: emits a one-cycle tick at an exact average rate
// FS_NUM/CLK_DEN of clk, and a registered ~50% duty sample strobe.
module fs_phase_accum #(
   parameter int FS_NUM    = 441,
   parameter int CLK_DEN   = 742500,
   parameter int ACC_WIDTH = 20
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick,
   output logic pcm_fs
);
   localparam logic [ACC_WIDTH-1:0] INC  = ACC_WIDTH'(FS_NUM);
   localparam logic [ACC_WIDTH-1:0] DEN  = ACC_WIDTH'(CLK_DEN);
   localparam logic [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(CLK_DEN / 2);

   logic [ACC_WIDTH-1:0] acc_q;
   logic [ACC_WIDTH-1:0] sum;
   logic [ACC_WIDTH-1:0] acc_nxt;

   always_comb begin
      sum     = acc_q + INC;
      tick    = (sum >= DEN);
      acc_nxt = tick ? (sum - DEN) : sum;
   end

   // Strobe falls once the phase passes half a sample period.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_q  <= '0;
         pcm_fs <= 1'b0;
      end else begin
         acc_q  <= acc_nxt;
         pcm_fs <= tick | (pcm_fs & (acc_nxt < HALF));
      end
   end
endmodule

// File: rtl/pcm_sample_scheduler.sv
// Audio sample scheduler: on every sample tick fetches one stereo sample from
// the selected source and presents it to hdmi_tx, logging failed fetches.
module pcm_sample_scheduler
   import pcm_sample_scheduler_pkg::*;
#(
   parameter int FS_NUM    = 441,
   parameter int CLK_DEN   = 742500,
   parameter int ACC_WIDTH = 20,
   parameter int PCM_WIDTH = 24,
   parameter int TIMEOUT   = 64,
   parameter int HOLD_LAST = 0
) (
   input logic                     clk,
   input logic                     reset_n,
   pcm_sample_scheduler_if.slave   bus
);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   logic                 tick;
   logic                 pcm_fs;
   state_t               state_q;
   sel_t                 sel_q;
   logic [WAIT_W-1:0]    wait_q;
   logic [PCM_WIDTH-1:0] pcm_l_q;
   logic [PCM_WIDTH-1:0] pcm_r_q;
   logic [7:0]           under_q;
   logic                 grant0, grant1;
   logic                 ready0, ready1;
   logic                 hs0, hs1;

   fs_phase_accum #(
      .FS_NUM   (FS_NUM),
      .CLK_DEN  (CLK_DEN),
      .ACC_WIDTH(ACC_WIDTH)
   ) u_accum (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .pcm_fs (pcm_fs)
   );

   // Priority mode falls back to src0 when neither source has data.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      case (sel_q)
         SEL_SRC0: grant0 = 1'b1;
         SEL_SRC1: grant1 = 1'b1;
         SEL_PRIO: begin
            if (bus.src0_valid)      grant0 = 1'b1;
            else if (bus.src1_valid) grant1 = 1'b1;
            else                     grant0 = 1'b1;
         end
         default: ;
      endcase
      ready0 = (state_q == ST_FETCH) & grant0;
      ready1 = (state_q == ST_FETCH) & grant1;
      hs0    = ready0 & bus.src0_valid;
      hs1    = ready1 & bus.src1_valid;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         sel_q   <= SEL_SRC0;
         wait_q  <= '0;
         pcm_l_q <= '0;
         pcm_r_q <= '0;
         under_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tick) begin
                  sel_q   <= bus.sel;
                  wait_q  <= '0;
                  state_q <= (bus.sel == SEL_MUTE) ? ST_MUTE : ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (hs0) begin
                  pcm_l_q <= bus.src0_l;
                  pcm_r_q <= bus.src0_r;
                  state_q <= ST_IDLE;
               end else if (hs1) begin
                  pcm_l_q <= bus.src1_l;
                  pcm_r_q <= bus.src1_r;
                  state_q <= ST_IDLE;
               end else if (wait_q == WAIT_LAST) begin
                  state_q <= ST_UNDER;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            ST_UNDER: begin
               if (HOLD_LAST == 0) begin
                  pcm_l_q <= '0;
                  pcm_r_q <= '0;
               end
               state_q <= ST_IDLE;
            end
            default: begin
               pcm_l_q <= '0;
               pcm_r_q <= '0;
               state_q <= ST_IDLE;
            end
         endcase
         // A tick landing outside IDLE is dropped and counted as a failed fetch.
         if ((state_q == ST_UNDER) || (tick && (state_q != ST_IDLE)))
            under_q <= sat_inc8(under_q);
      end
   end

   assign bus.src0_ready     = ready0;
   assign bus.src1_ready     = ready1;
   assign bus.pcm_fs         = pcm_fs;
   assign bus.pcm_l          = pcm_l_q;
   assign bus.pcm_r          = pcm_r_q;
   assign bus.underrun_count = under_q;
   assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_pcm_sample_scheduler.sv
// Directed bench for pcm_sample_scheduler: a default-rate instance for timing and
// fetch behaviour, and a fast-rate instance for rate exactness, hold and saturation.
module tb_pcm_sample_scheduler;
   import pcm_sample_scheduler_pkg::*;

   localparam int W = 24;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   pcm_sample_scheduler_if #(.PCM_WIDTH(W)) b0 ();
   pcm_sample_scheduler_if #(.PCM_WIDTH(W)) b1 ();

   pcm_sample_scheduler u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (b0)
   );

   // Fast instance: 7/200 of clk, so one exact rate window is 7 ticks in 200 clocks.
   pcm_sample_scheduler #(
      .FS_NUM   (7),
      .CLK_DEN  (200),
      .ACC_WIDTH(9),
      .PCM_WIDTH(W),
      .TIMEOUT  (8),
      .HOLD_LAST(1)
   ) u_fast (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (b1)
   );

   typedef struct {
      logic [1:0]   sel;
      logic         v0;
      logic         v1;
      logic [W-1:0] l0;
      logic [W-1:0] r0;
      logic [W-1:0] l1;
      logic [W-1:0] r1;
      logic         exp_rdy0;
      logic         exp_rdy1;
      logic [W-1:0] exp_l;
      logic [W-1:0] exp_r;
   } vec_t;

   vec_t         vecs[5];
   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic fs_of(input int which);
      return (which != 0) ? b1.pcm_fs : b0.pcm_fs;
   endfunction

   // Steps until a 0->1 edge of pcm_fs is seen; n = clocks taken.
   task automatic wait_rise(input int which, input int budget, output int n);
      logic prev;
      logic cur;
      bit   done;
      prev = fs_of(which);
      n    = 0;
      done = 0;
      while (!done) begin
         step();
         n++;
         cur = fs_of(which);
         if (cur && !prev) done = 1;
         prev = cur;
         if (!done && n >= budget) begin
            checks++;
            failures++;
            $display("FAIL wait_rise inst=%0d actual=no_edge required=edge_within_%0d", which, budget);
            done = 1;
         end
      end
   endtask

   // Called on a rise sample; measures clocks to the next rise and clocks high.
   task automatic period(input int which, output int hi, output int per);
      logic prev;
      logic cur;
      bit   done;
      hi   = 1;
      per  = 0;
      prev = 1'b1;
      done = 0;
      while (!done) begin
         step();
         per++;
         cur = fs_of(which);
         if (cur && !prev) done = 1;
         else begin
            if (cur) hi++;
            prev = cur;
         end
         if (!done && per >= 4000) begin
            checks++;
            failures++;
            $display("FAIL period inst=%0d actual=no_edge required=edge_within_4000", which);
            done = 1;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, hi, per, win;
      logic [W-1:0] el, er, prev_l;

      vecs[0] = '{sel: 2'd0, v0: 1'b1, v1: 1'b1, l0: 24'h123456, r0: 24'hABCDEF,
                  l1: 24'h111111, r1: 24'h222222, exp_rdy0: 1'b1, exp_rdy1: 1'b0,
                  exp_l: 24'h123456, exp_r: 24'hABCDEF};
      vecs[1] = '{sel: 2'd3, v0: 1'b1, v1: 1'b1, l0: 24'h123456, r0: 24'hABCDEF,
                  l1: 24'h111111, r1: 24'h222222, exp_rdy0: 1'b0, exp_rdy1: 1'b0,
                  exp_l: 24'h000000, exp_r: 24'h000000};
      vecs[2] = '{sel: 2'd1, v0: 1'b1, v1: 1'b1, l0: 24'h123456, r0: 24'hABCDEF,
                  l1: 24'h111111, r1: 24'h222222, exp_rdy0: 1'b0, exp_rdy1: 1'b1,
                  exp_l: 24'h111111, exp_r: 24'h222222};
      vecs[3] = '{sel: 2'd2, v0: 1'b0, v1: 1'b1, l0: 24'h123456, r0: 24'hABCDEF,
                  l1: 24'h000100, r1: 24'h000200, exp_rdy0: 1'b0, exp_rdy1: 1'b1,
                  exp_l: 24'h000100, exp_r: 24'h000200};
      vecs[4] = '{sel: 2'd2, v0: 1'b1, v1: 1'b1, l0: 24'h0A0A0A, r0: 24'h0B0B0B,
                  l1: 24'h000100, r1: 24'h000200, exp_rdy0: 1'b1, exp_rdy1: 1'b0,
                  exp_l: 24'h0A0A0A, exp_r: 24'h0B0B0B};

      b0.sel = SEL_MUTE; b0.src0_valid = 0; b0.src1_valid = 0;
      b0.src0_l = '0; b0.src0_r = '0; b0.src1_l = '0; b0.src1_r = '0;
      b1.sel = SEL_MUTE; b1.src0_valid = 0; b1.src1_valid = 0;
      b1.src0_l = '0; b1.src0_r = '0; b1.src1_l = '0; b1.src1_r = '0;

      // Reset state
      step_n(4);
      check("rst_pcm_fs", b0.pcm_fs, 0);
      check("rst_pcm_l", b0.pcm_l, 0);
      check("rst_pcm_r", b0.pcm_r, 0);
      check("rst_count", b0.underrun_count, 0);
      check("rst_ready", {b0.src0_ready, b0.src1_ready}, 0);
      check("rst_state", b0.dbg_state, ST_IDLE);

      // Tick in cycle 1684 after release; pcm_fs seen high after edge 1684 (cycle 1685).
      reset_n = 1'b1;
      wait_rise(0, 3000, n);
      check("first_fs_edges", n, 1684);
      step_n(3000 - n);
      check("run3000_count", b0.underrun_count, 0);
      check("run3000_state", b0.dbg_state, ST_IDLE);

      // Table-driven fetches, one per tick
      prev_l = '0;
      for (int i = 0; i < 5; i++) begin
         b0.sel = vecs[i].sel;
         b0.src0_valid = vecs[i].v0; b0.src1_valid = vecs[i].v1;
         b0.src0_l = vecs[i].l0; b0.src0_r = vecs[i].r0;
         b0.src1_l = vecs[i].l1; b0.src1_r = vecs[i].r1;
         exp_q.push_back(vecs[i].exp_l);
         exp_q.push_back(vecs[i].exp_r);
         wait_rise(0, 2000, n);
         check($sformatf("v%0d_rdy0", i), b0.src0_ready, vecs[i].exp_rdy0);
         check($sformatf("v%0d_rdy1", i), b0.src1_ready, vecs[i].exp_rdy1);
         check($sformatf("v%0d_l_stable_at_rise", i), b0.pcm_l, prev_l);
         step();
         el = exp_q.pop_front();
         er = exp_q.pop_front();
         check($sformatf("v%0d_pcm_l", i), b0.pcm_l, el);
         check($sformatf("v%0d_pcm_r", i), b0.pcm_r, er);
         check($sformatf("v%0d_rdy_after", i), {b0.src0_ready, b0.src1_ready}, 0);
         check($sformatf("v%0d_count", i), b0.underrun_count, 0);
         prev_l = el;
      end

      // Underrun: 64 FETCH clocks then one UNDER clock
      b0.sel = SEL_SRC0; b0.src0_valid = 0; b0.src1_valid = 0;
      wait_rise(0, 2000, n);
      check("under_rdy_start", b0.src0_ready, 1);
      step_n(63);
      check("under_fetch_last", b0.dbg_state, ST_FETCH);
      check("under_rdy_last", b0.src0_ready, 1);
      step();
      check("under_state", b0.dbg_state, ST_UNDER);
      check("under_rdy_drop", b0.src0_ready, 0);
      check("under_count_pre", b0.underrun_count, 0);
      step();
      check("under_count", b0.underrun_count, 1);
      check("under_pcm_l", b0.pcm_l, 0);
      check("under_pcm_r", b0.pcm_r, 0);
      check("under_idle", b0.dbg_state, ST_IDLE);

      // sel change mid-fetch: current fetch still completes from src0
      wait_rise(0, 2000, n);
      step_n(5);
      b0.sel = SEL_MUTE;
      step();
      check("selchg_rdy0", b0.src0_ready, 1);
      b0.src0_valid = 1; b0.src0_l = 24'h5A5A5A; b0.src0_r = 24'hA5A5A5;
      step();
      check("selchg_pcm_l", b0.pcm_l, 24'h5A5A5A);
      check("selchg_pcm_r", b0.pcm_r, 24'hA5A5A5);
      check("selchg_count", b0.underrun_count, 1);
      b0.src0_valid = 0;
      wait_rise(0, 2000, n);
      check("mute_state", b0.dbg_state, ST_MUTE);
      check("mute_rdy", {b0.src0_ready, b0.src1_ready}, 0);
      step();
      check("mute_pcm_l", b0.pcm_l, 0);
      check("mute_count", b0.underrun_count, 1);

      // Reset mid-fetch
      b0.sel = SEL_SRC0;
      wait_rise(0, 2000, n);
      step_n(10);
      check("rstmid_rdy_pre", b0.src0_ready, 1);
      reset_n = 1'b0;
      step();
      check("rstmid_rdy", b0.src0_ready, 0);
      check("rstmid_state", b0.dbg_state, ST_IDLE);
      check("rstmid_count", b0.underrun_count, 0);
      check("rstmid_fs", b0.pcm_fs, 0);
      check("rstmid_pcm_l", b0.pcm_l, 0);
      b0.sel = SEL_MUTE;
      step_n(2);
      reset_n = 1'b1;
      wait_rise(0, 3000, n);
      check("rerelease_fs_edges", n, 1684);

      // Default-rate tick spacing and strobe width
      for (int i = 0; i < 5; i++) begin
         period(0, hi, per);
         check_range($sformatf("dflt_period%0d", i), per, 1683, 1684);
         check_range($sformatf("dflt_high%0d", i), hi, 841, 843);
      end

      // Fast instance: HOLD_LAST keeps the last good sample on underrun
      b1.sel = SEL_SRC0; b1.src0_valid = 1;
      b1.src0_l = 24'h3C3C3C; b1.src0_r = 24'hC3C3C3;
      wait_rise(1, 100, n);
      check("fast_rdy0", b1.src0_ready, 1);
      step();
      check("fast_pcm_l", b1.pcm_l, 24'h3C3C3C);
      b1.src0_valid = 0;
      wait_rise(1, 100, n);
      step_n(9);
      check("hold_count", b1.underrun_count, 1);
      check("hold_pcm_l", b1.pcm_l, 24'h3C3C3C);
      check("hold_pcm_r", b1.pcm_r, 24'hC3C3C3);

      // Saturation of the underrun counter
      for (int i = 0; i < 253; i++) begin
         wait_rise(1, 100, n);
         step_n(9);
      end
      check("sat_count_254", b1.underrun_count, 254);
      for (int i = 0; i < 50; i++) begin
         wait_rise(1, 100, n);
         step_n(9);
      end
      check("sat_count_255", b1.underrun_count, 255);

      // Exact rate: every 7 consecutive ticks span 200 clocks
      wait_rise(1, 100, n);
      for (int w = 0; w < 2; w++) begin
         win = 0;
         for (int i = 0; i < 7; i++) begin
            period(1, hi, per);
            win += per;
            check_range($sformatf("fast_period%0d_%0d", w, i), per, 28, 29);
            check_range($sformatf("fast_high%0d_%0d", w, i), hi, 14, 15);
         end
         check($sformatf("fast_window%0d", w), win, 200);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
